wb_arbiter_2: RTL

//  Two-master Wishbone classic arbiter: shares one downstream bus between two requesters.

---
 rtl/wb_arbiter_2.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter_2.sv
// Two-master Wishbone classic arbiter.
// Round-robin ownership of one downstream bus, held for the owner's whole
// cyc assertion, with a per-transfer watchdog that answers silent accesses
// with a one-cycle err.
module wb_arbiter_2 #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int SELECT_WIDTH = DATA_WIDTH / 8,
   parameter int TIMEOUT      = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   wb_m0_adr_i,
   input  logic [DATA_WIDTH-1:0]   wb_m0_dat_i,
   output logic [DATA_WIDTH-1:0]   wb_m0_dat_o,
   input  logic                    wb_m0_we_i,
   input  logic                    wb_m0_stb_i,
   input  logic                    wb_m0_cyc_i,
   input  logic [SELECT_WIDTH-1:0] wb_m0_sel_i,
   output logic                    wb_m0_ack_o,
   output logic                    wb_m0_err_o,
   output logic                    wb_m0_rty_o,
   input  logic [ADDR_WIDTH-1:0]   wb_m1_adr_i,
   input  logic [DATA_WIDTH-1:0]   wb_m1_dat_i,
   output logic [DATA_WIDTH-1:0]   wb_m1_dat_o,
   input  logic                    wb_m1_we_i,
   input  logic                    wb_m1_stb_i,
   input  logic                    wb_m1_cyc_i,
   input  logic [SELECT_WIDTH-1:0] wb_m1_sel_i,
   output logic                    wb_m1_ack_o,
   output logic                    wb_m1_err_o,
   output logic                    wb_m1_rty_o,
   output logic [ADDR_WIDTH-1:0]   wb_s_adr_o,
   output logic [DATA_WIDTH-1:0]   wb_s_dat_o,
   input  logic [DATA_WIDTH-1:0]   wb_s_dat_i,
   output logic                    wb_s_we_o,
   output logic                    wb_s_stb_o,
   output logic                    wb_s_cyc_o,
   output logic [SELECT_WIDTH-1:0] wb_s_sel_o,
   input  logic                    wb_s_ack_i,
   input  logic                    wb_s_err_i,
   input  logic                    wb_s_rty_i,
   output logic [1:0]              grant_o
);

   // The watchdog needs to hold values up to TIMEOUT-1; keep one bit when disabled.
   localparam int WD_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WD_WIDTH-1:0] WD_LAST = (TIMEOUT > 0) ? WD_WIDTH'(TIMEOUT - 1) : '0;
   localparam logic [WD_WIDTH-1:0] WD_ONE  = WD_WIDTH'(1);

   typedef enum logic [1:0] {IDLE, BUSY, TOERR} state_t;

   state_t              state, state_next;
   logic                gnt, gnt_next;
   logic                last, last_next;
   logic [WD_WIDTH-1:0] wd, wd_next;
   logic                own_cyc, own_stb, reply, winner;

   // The owner's handshake lines and the arbitration winner, shared by both processes.
   assign own_cyc = gnt ? wb_m1_cyc_i : wb_m0_cyc_i;
   assign own_stb = gnt ? wb_m1_stb_i : wb_m0_stb_i;
   assign reply   = wb_s_ack_i | wb_s_err_i | wb_s_rty_i;
   assign winner  = (wb_m0_cyc_i & wb_m1_cyc_i) ? ~last : wb_m1_cyc_i;

   // State, owner, round-robin history and watchdog registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         gnt   <= 1'b0;
         last  <= 1'b1;
         wd    <= '0;
      end else begin
         state <= state_next;
         gnt   <= gnt_next;
         last  <= last_next;
         wd    <= wd_next;
      end
   end

   // Arbitration, release and watchdog decisions.
   always_comb begin
      state_next = state;
      gnt_next   = gnt;
      last_next  = last;
      wd_next    = wd;
      case (state)
         IDLE: begin
            wd_next = '0;
            if (wb_m0_cyc_i | wb_m1_cyc_i) begin
               gnt_next   = winner;
               last_next  = winner;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (!own_cyc) begin
               state_next = IDLE;
               wd_next    = '0;
            end else if (TIMEOUT == 0 || !own_stb || reply) begin
               wd_next = '0;
            end else if (wd == WD_LAST) begin
               state_next = TOERR;
               wd_next    = '0;
            end else if (wd != '1) begin
               wd_next = wd + WD_ONE;
            end
         end
         TOERR: begin
            wd_next    = '0;
            state_next = own_cyc ? BUSY : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Bus routing: pass-through for the owner in BUSY, a lone err in TOERR, silence otherwise.
   always_comb begin
      wb_s_adr_o  = '0;
      wb_s_dat_o  = '0;
      wb_s_we_o   = 1'b0;
      wb_s_stb_o  = 1'b0;
      wb_s_cyc_o  = 1'b0;
      wb_s_sel_o  = '0;
      wb_m0_dat_o = '0;
      wb_m0_ack_o = 1'b0;
      wb_m0_err_o = 1'b0;
      wb_m0_rty_o = 1'b0;
      wb_m1_dat_o = '0;
      wb_m1_ack_o = 1'b0;
      wb_m1_err_o = 1'b0;
      wb_m1_rty_o = 1'b0;
      grant_o     = 2'b00;
      case (state)
         BUSY: begin
            grant_o = gnt ? 2'b10 : 2'b01;
            if (gnt) begin
               wb_s_adr_o  = wb_m1_adr_i;
               wb_s_dat_o  = wb_m1_dat_i;
               wb_s_we_o   = wb_m1_we_i;
               wb_s_stb_o  = wb_m1_stb_i;
               wb_s_cyc_o  = wb_m1_cyc_i;
               wb_s_sel_o  = wb_m1_sel_i;
               wb_m1_dat_o = wb_s_dat_i;
               wb_m1_ack_o = wb_s_ack_i;
               wb_m1_err_o = wb_s_err_i;
               wb_m1_rty_o = wb_s_rty_i;
            end else begin
               wb_s_adr_o  = wb_m0_adr_i;
               wb_s_dat_o  = wb_m0_dat_i;
               wb_s_we_o   = wb_m0_we_i;
               wb_s_stb_o  = wb_m0_stb_i;
               wb_s_cyc_o  = wb_m0_cyc_i;
               wb_s_sel_o  = wb_m0_sel_i;
               wb_m0_dat_o = wb_s_dat_i;
               wb_m0_ack_o = wb_s_ack_i;
               wb_m0_err_o = wb_s_err_i;
               wb_m0_rty_o = wb_s_rty_i;
            end
         end
         TOERR: begin
            grant_o = gnt ? 2'b10 : 2'b01;
            if (gnt) wb_m1_err_o = 1'b1;
            else     wb_m0_err_o = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
